// File: rtl/fifo_tx_flex_pkg.sv
// rtl/fifo_tx_flex_pkg.sv - shared constants and helpers for the flexible SpaceWire TX FIFO
//
// Purpose : N-Char encoding constants and the depth derivation helper used by
//           the FIFO top level and its testbench.
// Ports   : none (package).
package fifo_tx_pkg;

  // Native N-Char width; the MSB flags a control character.
  localparam int NCHAR_WIDTH = 9;
  localparam int CTRL_BIT    = NCHAR_WIDTH - 1;

  // End-of-packet markers as they appear in the 9-bit stream.
  localparam logic [NCHAR_WIDTH-1:0] EOP = 9'h100;
  localparam logic [NCHAR_WIDTH-1:0] EEP = 9'h101;

  // Number of storage words for a given address width.
  function automatic int depth_of(input int awidth);
    return 1 << awidth;
  endfunction

endpackage

// File: rtl/fifo_tx_flex_if.sv
// rtl/fifo_tx_flex_if.sv - host/encoder bus bundle for the flexible TX FIFO
//
// Purpose : groups the write, read, flush, status and occupancy signals.
// Modports: master - host/encoder side (drives flush, wr_en, data_in, rd_en)
//           slave  - FIFO side (drives data_out, write_tx, flags, overflow, counter)
interface fifo_tx_flex_if #(
  parameter int DWIDTH = 9,
  parameter int AWIDTH = 6
);

  logic              flush;
  logic              wr_en;
  logic [DWIDTH-1:0] data_in;
  logic              rd_en;
  logic [DWIDTH-1:0] data_out;
  logic              write_tx;
  logic              f_full;
  logic              f_almost_full;
  logic              f_empty;
  logic              overflow;
  logic [AWIDTH:0]   counter;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, write_tx, f_full, f_almost_full, f_empty, overflow, counter
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, write_tx, f_full, f_almost_full, f_empty, overflow, counter
  );

endinterface

// File: rtl/fifo_tx_flex_ram.sv
// rtl/fifo_tx_flex_ram.sv - simple dual-port storage array for the TX FIFO
//
// Purpose : one synchronous write port and one read port whose address is
//           registered; read data follows the registered address
//           combinationally. No reset on the array or the address register.
// Ports   : clock   - rising-edge clock
//           we_i    - write enable
//           waddr_i - write address
//           wdata_i - write data
//           raddr_i - read address, captured on the clock edge
//           rdata_o - word at the captured read address
module fifo_tx_flex_ram #(
  parameter int DWIDTH = 9,
  parameter int AWIDTH = 6
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];
  logic [AWIDTH-1:0] raddr_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/fifo_tx_flex.sv
// rtl/fifo_tx_flex.sv - parametrised show-ahead SpaceWire transmit FIFO
//
// Purpose : buffers N-Chars from the host toward the TX encoder with a
//           one-entry prefetch register on the output, exact occupancy,
//           almost-full, overflow pulse and synchronous flush.
// Ports   : clock - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - fifo_tx_flex_if.slave (flush, wr_en, data_in, rd_en in;
//                   data_out, write_tx, f_full, f_almost_full, f_empty,
//                   overflow, counter out)
// Macro   : FIFO_TX_PACKET_MODE_EN - when defined, write_tx is held off until
//           a complete packet (EOP/EEP marker) is stored or the FIFO is full.
module fifo_tx_flex
  import fifo_tx_pkg::*;
#(
  parameter int DWIDTH   = 9,
  parameter int AWIDTH   = 6,
  parameter int AF_LEVEL = 56
) (
  input  logic          clock,
  input  logic          reset,
  fifo_tx_flex_if.slave bus
);

  localparam int              DEPTH   = depth_of(AWIDTH);
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              ovalid_q, ovalid_d;
  logic              f_full_q, f_full_d;
  logic              f_af_q, f_af_d;
  logic              f_empty_q, f_empty_d;
  logic              overflow_q, overflow_d;

  logic [DWIDTH-1:0] ram_rdata;
  logic [AWIDTH:0]   mem_count;
  logic              accept;
  logic              consume;
  logic              load;
  logic              write_tx;

  // Words still in the array: the prefetch register already holds one of
  // the counted words whenever it is valid.
  assign mem_count = count_q - {{AWIDTH{1'b0}}, ovalid_q};

`ifdef FIFO_TX_PACKET_MODE_EN
  localparam int CB = DWIDTH - 1;

  logic [AWIDTH:0] pkt_q, pkt_d;

  // The f_full escape lets a packet longer than the FIFO drain instead of
  // deadlocking with no marker ever arriving.
  assign write_tx = ovalid_q && ((pkt_q != '0) || f_full_q);

  always_comb begin
    pkt_d = pkt_q;
    if (bus.flush) begin
      pkt_d = '0;
    end else begin
      unique case ({accept && bus.data_in[CB], consume && dout_q[CB]})
        2'b10:   pkt_d = pkt_q + CNT_ONE;
        2'b01:   pkt_d = pkt_q - CNT_ONE;
        default: pkt_d = pkt_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end
`else
  assign write_tx = ovalid_q;
`endif

  always_comb begin
    accept  = bus.wr_en && !f_full_q && !bus.flush;
    consume = bus.rd_en && write_tx && !bus.flush;
    // Refill the prefetch register whenever it is empty or being drained,
    // so back-to-back consumes see no bubble.
    load    = (mem_count != '0) && (!ovalid_q || consume);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    ovalid_d   = ovalid_q;
    count_d    = count_q;
    overflow_d = 1'b0;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovalid_d = 1'b0;
      count_d  = '0;
    end else begin
      // Registered f_full decides rejection even when a read frees a slot.
      overflow_d = bus.wr_en && f_full_q;
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (load) begin
        dout_d   = ram_rdata;
        ovalid_d = 1'b1;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else if (consume) begin
        ovalid_d = 1'b0;
      end
      unique case ({accept, consume})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    f_full_d  = (count_d == DEPTH_C);
    f_af_d    = (count_d >= AF_C);
    f_empty_d = (count_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      ovalid_q   <= 1'b0;
      f_full_q   <= 1'b0;
      f_af_q     <= 1'b0;
      f_empty_q  <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      ovalid_q   <= ovalid_d;
      f_full_q   <= f_full_d;
      f_af_q     <= f_af_d;
      f_empty_q  <= f_empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Read address is the next-state pointer so the array output always
  // tracks the current head of the unread region.
  fifo_tx_flex_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clock   (clock),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  assign bus.data_out      = dout_q;
  assign bus.write_tx      = write_tx;
  assign bus.f_full        = f_full_q;
  assign bus.f_almost_full = f_af_q;
  assign bus.f_empty       = f_empty_q;
  assign bus.overflow      = overflow_q;
  assign bus.counter       = count_q;

endmodule

// File: doc/fifo_tx_flex.md
Name: fifo_tx_flex

Overview:
- Parametrised successor to the 64x9 SpaceWire transmit FIFO.
- Buffers 9-bit N-Char words (bit DWIDTH-1 = control flag) from the host write side toward the TX encoder.
- Adds:
  - configurable depth and width;
  - show-ahead output with valid/accept handshake at one word per clock;
  - exact occupancy counter and almost-full flag;
  - overflow error pulse and synchronous flush.

Parameters:
- DWIDTH, 9: word width; MSB is the N-Char control flag.
- AWIDTH, 6: address width; DEPTH = 2**AWIDTH words.
- AF_LEVEL, 56: f_almost_full asserts when counter >= AF_LEVEL. Legal range 1..DEPTH.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear; priority over wr_en and rd_en.
- wr_en  in  1  write request.
- data_in  in  DWIDTH  write data.
- rd_en  in  1  TX encoder accepts data_out; effective only while write_tx=1.
- data_out  out  DWIDTH  head-of-FIFO word, registered.
- write_tx  out  1  data_out valid.
- f_full  out  1  counter == DEPTH.
- f_almost_full  out  1  counter >= AF_LEVEL.
- f_empty  out  1  counter == 0.
- overflow  out  1  one-cycle pulse on a rejected write.
- counter  out  AWIDTH+1  words accepted and not yet consumed, 0..DEPTH.

Behaviour:
- Interface: one clock, `clock`; reset `reset` is asynchronous and active-high.
- Reset values: data_out=0, write_tx=0, f_full=0, f_almost_full=0, f_empty=1, overflow=0, counter=0. Pointers=0. Memory is not reset.
- Write accept:
  - accept = wr_en && !f_full, using the registered f_full.
  - On accept: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - wr_en while f_full: word dropped; overflow=1 next cycle. This holds even if a read occurs in the same cycle.
- Read consume:
  - consume = rd_en && write_tx.
  - rd_en while write_tx=0 is ignored; no pointer or counter change.
- Output stage:
  - data_out/write_tx form a one-entry prefetch register fed from memory at rd_ptr.
  - The register loads when empty, or on consume, if memory holds an unread word.
  - Back-to-back consumes sustain one word per clock with no bubble.
  - data_out holds steady while write_tx=1 and not consumed.
- Latency: a word accepted at edge N into an empty FIFO gives write_tx=1 and data_out=word after edge N+1.
- Counter:
  - +1 on accept only, -1 on consume only, unchanged on both or neither.
  - Never wraps; width AWIDTH+1 so DEPTH is representable.
  - Storage must hold DEPTH words including the output register.
- Flags:
  - Registered and computed from the next-state counter, so they change on the same edge as counter.
  - f_full and f_empty are never both 1.
- Flush: next edge sets pointers=0, counter=0, write_tx=0, f_empty=1, other flags=0, overflow=0. A coincident write is discarded without overflow.
- Reset mid-operation: immediate return to the reset values regardless of the clock. The first write after reset deasserts is accepted normally.
- Read/write FSMs: none. Handshake is single-cycle; no multi-cycle write or read states.

Optional Feature:
- Macro: FIFO_TX_PACKET_MODE_EN.
- Defined:
  - Internal packet counter counts stored words with MSB=1 (EOP/EEP markers).
  - +1 on accept of a marker, -1 on consume of a marker.
  - write_tx is gated: asserts only when pkt_count>0 or f_full=1. The f_full escape prevents deadlock on packets larger than DEPTH.
  - The prefetch register still loads; only valid is masked.
- Undefined: write_tx as specified above; no packet counter is synthesised.

Decomposition:
- Package fifo_tx_pkg holds:
  - CTRL_BIT index (DWIDTH-1);
  - N-Char codes EOP=9'h100, EEP=9'h101;
  - DEPTH derivation helper.
- Sub-module fifo_tx_flex_ram: simple dual-port, one write port, one registered-address read port, no reset.
- Pointer, counter and output-stage logic stay in the top level.

Test Plan (defaults, DEPTH=64, AF_LEVEL=56):
- Reset then write 0x0A1 with rd_en=0 -> write_tx=1 and data_out=0x0A1 one edge later; counter=1, f_empty=0.
- Write 64 words 0..63 with rd_en=0 -> f_almost_full rises at counter=56; f_full=1 at 64. 65th write -> overflow pulse; counter stays 64. Draining reads 0..63 in order.
- Full FIFO, wr_en=1 and rd_en=1 for 1 cycle -> write rejected, overflow=1, counter=63.
- Continuous wr_en and rd_en for 200 words with a half-full start -> counter constant, order preserved across pointer wrap, no bubbles on write_tx.
- Flush at counter=20 with wr_en=1 -> counter=0, write_tx=0, f_empty=1, overflow=0. Next write is read back correctly.
- With FIFO_TX_PACKET_MODE_EN: write 5 data words, write_tx stays 0; write EOP 0x100 -> write_tx=1. All 6 words stream out; write_tx drops after the EOP is consumed.
